uart_rx_ctrl: RTL

//   Receive-side sequencer for the UART rx baud generator. Detects the start bit and

---
 rtl/uart_rx_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// Receive-side sequencer for an oversampling UART: detects the start bit, drives the
// baud generator via byte_en/rx_done, majority-votes each bit and delivers 8N1 bytes.
module uart_rx_ctrl #(
    parameter int DATA_BITS      = 8,
    parameter int OVERSAMPLE     = 9,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 bps_clk,
    output logic                 byte_en,
    output logic                 rx_done,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 frame_err
);

    localparam int BIT_W = 3;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]      TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state_reg, state_next;
    logic                 rx_meta_reg, rx_sync_reg, rx_prev_reg;
    logic [3:0]           tick_cnt_reg, tick_cnt_next;
    logic [BIT_W-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [1:0]           vote_cnt_reg, vote_cnt_next;
    logic [DATA_BITS-1:0] shift_data_reg, shift_data_next;
    logic [WD_W-1:0]      wd_cnt_reg, wd_cnt_next;
    logic [DATA_BITS-1:0] data_reg, data_next;
    logic                 byte_en_reg, byte_en_next;
    logic                 rx_done_reg, rx_done_next;
    logic                 data_valid_reg, data_valid_next;
    logic                 frame_err_reg, frame_err_next;

    logic       fall;
    logic       decide;
    logic       wrap;
    logic       timeout;
    logic [2:0] vote_sum;
    logic       majority;

    assign fall     = rx_prev_reg & ~rx_sync_reg;
    assign decide   = bps_clk && (tick_cnt_reg == 4'd5);
    assign wrap     = bps_clk && (tick_cnt_reg == TICK_LAST);
    assign timeout  = (state_reg != IDLE) && !bps_clk && (wd_cnt_reg == WD_LAST);
    // Ticks 3 and 4 are already accumulated; the tick-5 sample joins combinationally.
    assign vote_sum = {1'b0, vote_cnt_reg} + {2'b00, rx_sync_reg};
    assign majority = (vote_sum >= 3'd2);

    always_comb begin
        state_next      = state_reg;
        tick_cnt_next   = tick_cnt_reg;
        bit_cnt_next    = bit_cnt_reg;
        vote_cnt_next   = vote_cnt_reg;
        shift_data_next = shift_data_reg;
        wd_cnt_next     = '0;
        data_next       = data_reg;
        byte_en_next    = 1'b0;
        rx_done_next    = 1'b0;
        data_valid_next = 1'b0;
        frame_err_next  = 1'b0;

        if (state_reg != IDLE) begin
            wd_cnt_next = bps_clk ? '0 : wd_cnt_reg + 1'b1;
            if (bps_clk) begin
                tick_cnt_next = wrap ? 4'd0 : tick_cnt_reg + 4'd1;
                if (tick_cnt_reg == 4'd3 || tick_cnt_reg == 4'd4)
                    vote_cnt_next = vote_cnt_reg + {1'b0, rx_sync_reg};
                else if (decide)
                    vote_cnt_next = 2'd0;
            end
        end

        unique case (state_reg)
            IDLE: begin
                if (fall) begin
                    byte_en_next  = 1'b1;
                    tick_cnt_next = 4'd0;
                    bit_cnt_next  = '0;
                    vote_cnt_next = 2'd0;
                    state_next    = START;
                end
            end
            START: begin
                if (decide && majority) begin
                    rx_done_next = 1'b1;
                    state_next   = IDLE;
                end else if (wrap) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (decide)
                    shift_data_next = {majority, shift_data_reg[DATA_BITS-1:1]};
                if (wrap) begin
                    if (bit_cnt_reg == BIT_LAST) begin
                        bit_cnt_next = '0;
                        state_next   = STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            STOP: begin
                // Decide mid stop bit so the next start edge can never be missed.
                if (decide) begin
                    rx_done_next = 1'b1;
                    state_next   = IDLE;
                    if (majority) begin
                        data_next       = shift_data_reg;
                        data_valid_next = 1'b1;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (timeout) begin
            state_next      = IDLE;
            rx_done_next    = 1'b1;
            data_valid_next = 1'b0;
            frame_err_next  = 1'b0;
            data_next       = data_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_reg    <= 1'b1;
            rx_sync_reg    <= 1'b1;
            rx_prev_reg    <= 1'b1;
            state_reg      <= IDLE;
            tick_cnt_reg   <= 4'd0;
            bit_cnt_reg    <= '0;
            vote_cnt_reg   <= 2'd0;
            shift_data_reg <= '0;
            wd_cnt_reg     <= '0;
            data_reg       <= '0;
            byte_en_reg    <= 1'b0;
            rx_done_reg    <= 1'b0;
            data_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            rx_meta_reg    <= rx;
            rx_sync_reg    <= rx_meta_reg;
            rx_prev_reg    <= rx_sync_reg;
            state_reg      <= state_next;
            tick_cnt_reg   <= tick_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            vote_cnt_reg   <= vote_cnt_next;
            shift_data_reg <= shift_data_next;
            wd_cnt_reg     <= wd_cnt_next;
            data_reg       <= data_next;
            byte_en_reg    <= byte_en_next;
            rx_done_reg    <= rx_done_next;
            data_valid_reg <= data_valid_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    assign byte_en    = byte_en_reg;
    assign rx_done    = rx_done_reg;
    assign data       = data_reg;
    assign data_valid = data_valid_reg;
    assign frame_err  = frame_err_reg;

endmodule
